// File: rtl/sevenseg_scan_ctrl.sv
// sevenseg_scan_ctrl
//
// Time-multiplexed scan controller for an N-digit common-anode seven-segment
// display. It sits in front of a hex-to-segment decoder. It holds a multi-digit
// hex value and presents one nibble at a time on Nibble_out, together with the
// matching anode enable on Anode_out.
//
// Handshake: Ready is high whenever no value is pending. A cycle with Load=1
// and Ready=1 captures Value_in into the pending register, and Ready drops on
// the next cycle. Load while Ready=0 is ignored. A pending value moves into the
// display register only at a frame boundary, so a shown value never tears.
// Ready returns high on the cycle after that transfer.
//
// Ports:
//   Clk         system clock; all logic on the rising edge
//   Rst         synchronous active-high reset
//   Load        request to capture Value_in (honoured only while Ready=1)
//   Value_in    hex value; nibble k is digit k (digit 0 = least significant)
//   Blank_lz    1 = blank leading zero digits (sampled every cycle)
//   Ready       1 = no pending value; Load will be accepted
//   Nibble_out  nibble of the current digit, for the decoder data input
//   Anode_out   one-hot digit enable; active low when ANODE_ACTIVE_LOW=1
//   Blank_out   1 = current digit blanked; ignore the decoder output
//   Frame_done  one-cycle pulse after the scan wraps from the last digit to 0

module sevenseg_scan_ctrl #(
    parameter int NUM_DIGITS       = 4,
    parameter int PRESCALE         = 50000,
    parameter bit ANODE_ACTIVE_LOW = 1'b1
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic                    Load,
    input  logic [4*NUM_DIGITS-1:0] Value_in,
    input  logic                    Blank_lz,
    output logic                    Ready,
    output logic [3:0]              Nibble_out,
    output logic [NUM_DIGITS-1:0]   Anode_out,
    output logic                    Blank_out,
    output logic                    Frame_done
);

    localparam int CNT_W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0]      CNT_LAST      = CNT_W'(PRESCALE - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST      = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] ANODE_OFF     = ANODE_ACTIVE_LOW ? '1 : '0;

    logic [CNT_W-1:0]        cnt;
    logic [IDX_W-1:0]        idx;
    logic [4*NUM_DIGITS-1:0] display;
    logic [4*NUM_DIGITS-1:0] pending;
    logic                    pend_flag;

    logic                    tick;
    logic                    frame_end;
    logic [NUM_DIGITS-1:0]   upper_zero;
    logic                    zero_run;
    logic                    blank_now;
    logic [NUM_DIGITS-1:0]   onehot;

    assign tick      = (cnt == CNT_LAST);
    assign frame_end = tick && (idx == IDX_LAST);
    assign Ready     = ~pend_flag;

    // Prescaler, digit index and the pending/display handshake.
    // A boundary with a pending value takes priority. Ready is 0 in that
    // cycle, so a simultaneous Load could not be accepted anyway. A boundary
    // without a pending value still accepts a Load. That value then waits in
    // pending for the next boundary.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            cnt       <= '0;
            idx       <= '0;
            display   <= '0;
            pending   <= '0;
            pend_flag <= 1'b0;
        end else begin
            if (tick) begin
                cnt <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
            end else begin
                cnt <= cnt + CNT_W'(1);
            end

            if (frame_end && pend_flag) begin
                display   <= pending;
                pend_flag <= 1'b0;
            end else if (Load && !pend_flag) begin
                pending   <= Value_in;
                pend_flag <= 1'b1;
            end
        end
    end

    // upper_zero[k] = display nibbles k..NUM_DIGITS-1 are all zero.
    always_comb begin
        zero_run   = 1'b1;
        upper_zero = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_run      = zero_run & (display[4*k +: 4] == 4'd0);
            upper_zero[k] = zero_run;
        end
    end

    always_comb begin
        blank_now = Blank_lz && (idx != '0) && upper_zero[idx];
        onehot    = '0;
        onehot[idx] = 1'b1;
    end

    // Registered outputs: one cycle behind idx/display.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            Nibble_out <= 4'd0;
            Anode_out  <= ANODE_OFF;
            Blank_out  <= 1'b1;
            Frame_done <= 1'b0;
        end else begin
            Nibble_out <= display[4*idx +: 4];
            Frame_done <= frame_end;
            if (blank_now) begin
                Anode_out <= ANODE_OFF;
                Blank_out <= 1'b1;
            end else begin
                Anode_out <= ANODE_ACTIVE_LOW ? ~onehot : onehot;
                Blank_out <= 1'b0;
            end
        end
    end

endmodule
